// File: rtl/rom_access_arbiter.sv
// Shares one ROM among N_REQ requesters: grant, wait ROM_LAT cycles, capture word, pulse Ack.
// Define ROMARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module rom_access_arbiter #(
   parameter int N_REQ   = 3,
   parameter int ROM_LAT = 2,
   parameter int AW      = 5,
   parameter int DW      = 24
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    Req,
   input  logic [N_REQ*AW-1:0] Req_addr,
   input  logic [DW-1:0]       ROM_data,
   output logic [AW-1:0]       ROM_addr,
   output logic [N_REQ-1:0]    Gnt,
   output logic [N_REQ-1:0]    Ack,
   output logic [DW-1:0]       Rd_data,
   output logic                Busy,
   output logic [1:0]          state_dbg
);

   // Handshake: Req is a level held by requester i until it sees its own one-cycle Ack;
   // Rd_data is valid in the Ack cycle and held until the next capture.

   localparam int LW = $clog2(N_REQ);
   localparam int CW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_CAPTURE = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t         state;
   state_t         state_next;
   logic [LW-1:0]  last;
   logic [LW-1:0]  win;
   logic [LW-1:0]  idx;
   logic           found;
   logic [CW-1:0]  cnt;
   logic           grant_en;
   logic           capture_en;
   logic           release_en;
   logic           wait_en;
   logic [AW-1:0]  addr_arr [N_REQ];

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         addr_arr[i] = Req_addr[i*AW +: AW];
      end
   end

   // Winner selection; only consumed on the grant edge.
   always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
`ifdef ROMARB_FIXED_PRIO_EN
      for (int i = N_REQ-1; i >= 0; i--) begin
         if (Req[i]) begin
            win = LW'(i);
         end
      end
      found = |Req;
`else
      for (int k = 1; k <= N_REQ; k++) begin
         idx = LW'((int'(last) + k) % N_REQ);
         if (!found && Req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:    if (found) state_next = S_WAIT;
         S_WAIT:    if (cnt == CW'(ROM_LAT-1)) state_next = S_CAPTURE;
         S_CAPTURE: state_next = S_RELEASE;
         S_RELEASE: state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   always_comb begin
      grant_en   = (state == S_IDLE) && found;
      wait_en    = (state == S_WAIT);
      capture_en = (state == S_CAPTURE);
      release_en = (state == S_RELEASE);
      Busy       = (state != S_IDLE);
      state_dbg  = state;
   end

   // ROM_addr is only reloaded at a grant, so it stays stable through the whole read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ROM_addr <= '0;
         Gnt      <= '0;
         Ack      <= '0;
         Rd_data  <= '0;
         cnt      <= '0;
         last     <= LW'(N_REQ-1);
      end else begin
         if (grant_en) begin
            Gnt      <= N_REQ'(1) << win;
            ROM_addr <= addr_arr[win];
            last     <= win;
            cnt      <= '0;
         end else if (wait_en) begin
            cnt <= cnt + 1'b1;
         end
         if (capture_en) begin
            Rd_data <= ROM_data;
            Ack     <= Gnt;
            Gnt     <= '0;
         end
         if (release_en) begin
            Ack <= '0;
         end
      end
   end

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Scenario bench for rom_access_arbiter with a 2-stage ROM model and an Ack/Rd_data scoreboard.
module tb_rom_access_arbiter;

   localparam int N  = 3;
   localparam int AW = 5;
   localparam int DW = 24;
   localparam int EW = N + DW;

   logic            clk;
   logic            rst;
   logic [N-1:0]    Req;
   logic [N*AW-1:0] Req_addr;
   logic [DW-1:0]   ROM_data;
   logic [AW-1:0]   ROM_addr;
   logic [N-1:0]    Gnt;
   logic [N-1:0]    Ack;
   logic [DW-1:0]   Rd_data;
   logic            Busy;
   logic [1:0]      state_dbg;

   logic [DW-1:0]   mem [32];
   logic [DW-1:0]   rom_s1;
   logic [EW-1:0]   exp_q [$];
   int              tests;
   int              fails;
   int              cycle;

   rom_access_arbiter #(.N_REQ(N), .ROM_LAT(2), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst), .Req(Req), .Req_addr(Req_addr), .ROM_data(ROM_data),
      .ROM_addr(ROM_addr), .Gnt(Gnt), .Ack(Ack), .Rd_data(Rd_data), .Busy(Busy),
      .state_dbg(state_dbg)
   );

   // clock / cycle counter / ROM model
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cycle  <= cycle + 1;
      rom_s1 <= mem[ROM_addr];
      ROM_data <= rom_s1;
   end

   // scoreboard and invariants
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (rst) begin
         if (|Ack) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL ack_unexpected: Ack=%b Rd_data=%h, required no Ack", Ack, Rd_data);
            end else begin
               e = exp_q.pop_front();
               if ({Ack, Rd_data} !== e) begin
                  fails++;
                  $display("FAIL ack_data: Ack=%b Rd_data=%h, required Ack=%b Rd_data=%h",
                           Ack, Rd_data, e[EW-1 -: N], e[DW-1:0]);
               end
            end
         end
         tests++;
         if ((Gnt & Ack) != 0 || !$onehot0(Gnt) || !$onehot0(Ack)) begin
            fails++;
            $display("FAIL onehot: Gnt=%b Ack=%b, required one-hot and disjoint", Gnt, Ack);
         end
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_addr(input int i, input logic [AW-1:0] a);
      Req_addr[i*AW +: AW] = a;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      Req = '0;
      repeat (3) step();
      rst = 1'b1;
   endtask

   task automatic wait_ack(output int cyc, output bit ok);
      ok  = 1'b0;
      cyc = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (|Ack) begin
            cyc = cycle;
            ok  = 1'b1;
            return;
         end
      end
   endtask

   task automatic next_grant(output logic [N-1:0] g, output int cyc, output bit ok);
      ok  = 1'b0;
      g   = '0;
      cyc = 0;
      for (int i = 0; i < 20 && Gnt != 0; i++) step();
      for (int i = 0; i < 20; i++) begin
         step();
         if (Gnt != 0) begin
            g   = Gnt;
            cyc = cycle;
            ok  = 1'b1;
            return;
         end
      end
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (!Busy) begin
            ok = 1'b1;
            break;
         end
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL idle_timeout: Busy=%b, required 0 within 20 cycles", Busy);
      end
      repeat (2) step();
   endtask

   // scenarios
   task automatic test_reset();
      rst = 1'b0;
      Req = '0;
      Req_addr = '0;
      repeat (2) step();
      tests++;
      if ({ROM_addr, Gnt, Ack, Rd_data, Busy, state_dbg} !== '0) begin
         fails++;
         $display("FAIL reset_values: addr=%h gnt=%b ack=%b rd=%h busy=%b st=%0d, required all 0",
                  ROM_addr, Gnt, Ack, Rd_data, Busy, state_dbg);
      end
      rst = 1'b1;
      step();
   endtask

   task automatic test_idle();
      for (int i = 0; i < 5; i++) begin
         step();
         tests++;
         if (Gnt !== '0 || Ack !== '0 || Busy !== 1'b0 || ROM_addr !== '0) begin
            fails++;
            $display("FAIL idle_static: gnt=%b ack=%b busy=%b addr=%h, required 0/0/0/0",
                     Gnt, Ack, Busy, ROM_addr);
         end
      end
   endtask

   task automatic test_single();
      int t, ta;
      bit ok;
      logic [N-1:0] g;
      set_addr(0, 5'd3);
      Req = 3'b001;
      exp_q.push_back({3'b001, 24'h123456});
      next_grant(g, t, ok);
      tests++;
      if (!ok || g !== 3'b001 || ROM_addr !== 5'd3 || Busy !== 1'b1) begin
         fails++;
         $display("FAIL single_grant: gnt=%b addr=%0d busy=%b, required 001/3/1", g, ROM_addr, Busy);
      end
      wait_ack(ta, ok);
      Req = '0;
      tests++;
      if (!ok || ta - t != 3) begin
         fails++;
         $display("FAIL single_latency: ack after %0d cycles, required 3", ta - t);
      end
      step();
      tests++;
      if (Busy !== 1'b0 || Ack !== '0) begin
         fails++;
         $display("FAIL single_release: busy=%b ack=%b at t+4, required 0/000", Busy, Ack);
      end
      repeat (3) step();
   endtask

   task automatic test_simultaneous();
      logic [N-1:0] ord [4];
      logic [N-1:0] g;
      int t, tp;
      bit ok;
`ifdef ROMARB_FIXED_PRIO_EN
      ord = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
      ord = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
      do_reset();
      set_addr(0, 5'd1);
      set_addr(1, 5'd2);
      set_addr(2, 5'd3);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({ord[i], mem[$clog2(ord[i]) + 1]});
      end
      Req = 3'b111;
      tp = 0;
      for (int i = 0; i < 4; i++) begin
         next_grant(g, t, ok);
         if (i == 3) Req = '0;
         tests++;
         if (!ok || g !== ord[i]) begin
            fails++;
            $display("FAIL rr_order[%0d]: gnt=%b, required %b", i, g, ord[i]);
         end
         if (i > 0) begin
            tests++;
            if (t - tp != 5) begin
               fails++;
               $display("FAIL rr_spacing[%0d]: %0d cycles, required 5", i, t - tp);
            end
         end
         tp = t;
      end
      wait_idle();
   endtask

   task automatic test_reset_mid_op();
      int t;
      bit ok;
      logic [N-1:0] g;
      set_addr(0, 5'd9);
      Req = 3'b001;
      next_grant(g, t, ok);
      step();
      rst = 1'b0;
      Req = '0;
      #1;
      tests++;
      if (Gnt !== '0 || Ack !== '0 || ROM_addr !== '0 || Busy !== 1'b0 || Rd_data !== '0) begin
         fails++;
         $display("FAIL midop_reset: gnt=%b ack=%b addr=%h busy=%b rd=%h, required all 0",
                  Gnt, Ack, ROM_addr, Busy, Rd_data);
      end
      repeat (2) step();
      rst = 1'b1;
      step();
      set_addr(1, 5'd6);
      Req = 3'b010;
      exp_q.push_back({3'b010, mem[6]});
      next_grant(g, t, ok);
      tests++;
      if (!ok || g !== 3'b010 || ROM_addr !== 5'd6) begin
         fails++;
         $display("FAIL midop_after: gnt=%b addr=%0d, required 010/6", g, ROM_addr);
      end
      wait_ack(t, ok);
      Req = '0;
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL midop_ack: no Ack, required Ack=010");
      end
      wait_idle();
   endtask

   task automatic test_early_drop();
      int t, ta, extra;
      bit ok;
      logic [N-1:0] g;
      set_addr(2, 5'd12);
      Req = 3'b100;
      exp_q.push_back({3'b100, mem[12]});
      next_grant(g, t, ok);
      Req = '0;
      wait_ack(ta, ok);
      tests++;
      if (!ok || g !== 3'b100 || ta - t != 3) begin
         fails++;
         $display("FAIL early_drop_ack: gnt=%b ack after %0d, required 100 after 3", g, ta - t);
      end
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (Gnt != 0) extra++;
      end
      tests++;
      if (extra != 0) begin
         fails++;
         $display("FAIL early_drop_regrant: %0d grant cycles, required 0", extra);
      end
   endtask

   task automatic test_addr_change();
      int t;
      bit ok, bad;
      logic [N-1:0] g;
      set_addr(0, 5'd4);
      Req = 3'b001;
      exp_q.push_back({3'b001, mem[4]});
      next_grant(g, t, ok);
      set_addr(0, 5'd7);
      bad = (ROM_addr !== 5'd4);
      for (int i = 0; i < 3; i++) begin
         step();
         if (ROM_addr !== 5'd4) bad = 1'b1;
      end
      Req = '0;
      tests++;
      if (!ok || bad) begin
         fails++;
         $display("FAIL addr_hold: ROM_addr=%0d, required 4 throughout", ROM_addr);
      end
      wait_idle();
   endtask

   task automatic test_priority_mode();
      logic [N-1:0] ord [4];
      logic [N-1:0] g;
      int t;
      bit ok;
`ifdef ROMARB_FIXED_PRIO_EN
      ord = '{3'b001, 3'b001, 3'b001, 3'b010};
`else
      ord = '{3'b010, 3'b001, 3'b010, 3'b001};
`endif
      set_addr(0, 5'd10);
      set_addr(1, 5'd11);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({ord[i], (ord[i] == 3'b001) ? mem[10] : mem[11]});
      end
      Req = 3'b011;
      for (int i = 0; i < 4; i++) begin
         next_grant(g, t, ok);
`ifdef ROMARB_FIXED_PRIO_EN
         if (i == 2) Req = 3'b010;
`endif
         if (i == 3) Req = '0;
         tests++;
         if (!ok || g !== ord[i]) begin
            fails++;
            $display("FAIL prio_order[%0d]: gnt=%b, required %b", i, g, ord[i]);
         end
      end
      wait_idle();
   endtask

   initial begin
      tests = 0;
      fails = 0;
      cycle = 0;
      for (int i = 0; i < 32; i++) mem[i] = DW'($urandom_range(0, 24'hFFFFFF));
      mem[3] = 24'h123456;
      test_reset();
      test_idle();
      test_single();
      test_simultaneous();
      test_reset_mid_op();
      test_early_drop();
      test_addr_change();
      test_priority_mode();
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d pending, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
